// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 key schedule sequencer.
package aes_pkg;

    localparam int unsigned AES_ROUNDS = 10;
    localparam int unsigned KEY_W      = 128;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned CNT_W      = 4;

    // Key bus uses [0:127] numbering, bit 0 is the MSB
    typedef logic [0:KEY_W-1] aes_key_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } ks_state_t;

    // Round constants, byte [0:7] significant, remaining bits zero
    localparam logic [0:WORD_W-1] RCON [1:AES_ROUNDS] = '{
        32'h01000000, 32'h02000000, 32'h04000000, 32'h08000000, 32'h10000000,
        32'h20000000, 32'h40000000, 32'h80000000, 32'h1b000000, 32'h36000000
    };

    // Lookup with out-of-range rounds mapping to zero
    function automatic logic [0:WORD_W-1] rcon(input logic [CNT_W-1:0] n);
        if ((n >= CNT_W'(1)) && (n <= CNT_W'(AES_ROUNDS)))
            rcon = RCON[n];
        else
            rcon = '0;
    endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_key_gen.sv
// Combinational AES-128 round-key stage: next round key from previous key and rcon.
module key_gen
    import aes_pkg::*;
(
    input  logic [0:127] prev_key,
    input  logic [0:31]  rcon_in,
    output logic [0:127] next_key
);

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        sub_byte = SBOX[{b, 3'b000} +: 8];
    endfunction

    logic [0:31] w0, w1, w2, w3, rot_w, sub_w, tmp_w, n0, n1, n2, n3;

    // RotWord, SubWord, rcon mix, then the xor chain across the four words
    always_comb begin
        w0       = prev_key[0:31];
        w1       = prev_key[32:63];
        w2       = prev_key[64:95];
        w3       = prev_key[96:127];
        rot_w    = {w3[8:31], w3[0:7]};
        sub_w    = {sub_byte(rot_w[0:7]),   sub_byte(rot_w[8:15]),
                    sub_byte(rot_w[16:23]), sub_byte(rot_w[24:31])};
        tmp_w    = sub_w ^ rcon_in;
        n0       = w0 ^ tmp_w;
        n1       = w1 ^ n0;
        n2       = w2 ^ n1;
        n3       = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 decryption key-schedule sequencer: expands a key into an 11-entry
// round-key store and serves indexed reads. Optional AES_KS_ZEROIZE_EN adds a
// zeroize input that wipes the store and returns to IDLE.
module aes_key_sched_ctrl
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
`ifdef AES_KS_ZEROIZE_EN
    input  logic         zeroize,
`endif
    input  logic [0:127] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         busy,
    output logic         keys_ready,
    input  logic         rk_rd,
    input  logic [3:0]   rk_idx,
    output logic [0:127] rk_out,
    output logic         rk_vld
);

    ks_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] src_idx_c;
    aes_key_t         store [0:AES_ROUNDS];
    aes_key_t         gen_key_c;
    logic             accept_c;
    logic             zero_c;

`ifdef AES_KS_ZEROIZE_EN
    assign zero_c = zeroize;
`else
    assign zero_c = 1'b0;
`endif

    assign accept_c  = key_valid & key_ready;
    assign src_idx_c = (cnt == '0) ? '0 : cnt - CNT_W'(1);

    key_gen u_key_gen (
        .prev_key (store[src_idx_c]),
        .rcon_in  (rcon(cnt)),
        .next_key (gen_key_c)
    );

    // Sequencer state, round counter and state-decoded status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            key_ready  <= 1'b1;
            busy       <= 1'b0;
            keys_ready <= 1'b0;
        end else if (zero_c) begin
            state      <= IDLE;
            cnt        <= '0;
            key_ready  <= 1'b1;
            busy       <= 1'b0;
            keys_ready <= 1'b0;
        end else begin
            case (state)
                IDLE, READY: begin
                    if (accept_c) begin
                        state      <= EXPAND;
                        cnt        <= CNT_W'(1);
                        key_ready  <= 1'b0;
                        busy       <= 1'b1;
                        keys_ready <= 1'b0;
                    end
                end
                EXPAND: begin
                    if (cnt == CNT_W'(AES_ROUNDS)) begin
                        state      <= READY;
                        key_ready  <= 1'b1;
                        busy       <= 1'b0;
                        keys_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    key_ready  <= 1'b1;
                    busy       <= 1'b0;
                    keys_ready <= 1'b0;
                end
            endcase
        end
    end

    // Round-key store: flop array so reset and zeroize can clear it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= int'(AES_ROUNDS); i++) store[i] <= '0;
        end else if (zero_c) begin
            for (int i = 0; i <= int'(AES_ROUNDS); i++) store[i] <= '0;
        end else if (accept_c) begin
            store[0] <= key_in;
        end else if (state == EXPAND) begin
            store[cnt] <= gen_key_c;
        end
    end

    // Read port: samples the store before any same-edge write lands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rk_out <= '0;
            rk_vld <= 1'b0;
        end else if (zero_c) begin
            rk_out <= '0;
            rk_vld <= 1'b0;
        end else if (rk_rd && keys_ready) begin
            rk_vld <= 1'b1;
            rk_out <= (rk_idx > 4'(AES_ROUNDS)) ? '0 : store[rk_idx];
        end else begin
            rk_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl using FIPS-197 key schedules.
`timescale 1ns/1ps
module tb_aes_key_sched_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [0:127] key_in;
    logic         key_valid;
    logic         key_ready, busy, keys_ready;
    logic         rk_rd;
    logic [3:0]   rk_idx;
    logic [0:127] rk_out;
    logic         rk_vld;
`ifdef AES_KS_ZEROIZE_EN
    logic         zeroize;
`endif

    int n_vec = 0;
    int n_err = 0;

    aes_key_sched_ctrl dut (
        .clk        (clk),
        .rst        (rst),
`ifdef AES_KS_ZEROIZE_EN
        .zeroize    (zeroize),
`endif
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .busy       (busy),
        .keys_ready (keys_ready),
        .rk_rd      (rk_rd),
        .rk_idx     (rk_idx),
        .rk_out     (rk_out),
        .rk_vld     (rk_vld)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] exp;
    } vec_t;

    localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_C1   = 128'h000102030405060708090a0b0c0d0e0f;

    vec_t tab [12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b, want %0b", name, act, exp);
        end
    endtask

    task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk1({tag, " key_ready"}, key_ready, 1'b1);
        chk1({tag, " busy"}, busy, 1'b0);
        chk1({tag, " keys_ready"}, keys_ready, 1'b0);
        chk1({tag, " rk_vld"}, rk_vld, 1'b0);
        chk128({tag, " rk_out"}, rk_out, 128'h0);
    endtask

    task automatic read_key(input string name, input logic [3:0] idx, input logic [127:0] exp);
        rk_rd  = 1'b1;
        rk_idx = idx;
        step();
        rk_rd  = 1'b0;
        chk1({name, " vld"}, rk_vld, 1'b1);
        chk128({name, " key"}, rk_out, exp);
    endtask

    initial begin
        tab[0]  = '{4'd15, 128'h0};
        tab[1]  = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        tab[2]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
        tab[3]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
        tab[4]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
        tab[5]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
        tab[6]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        tab[7]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
        tab[8]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        tab[9]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
        tab[10] = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        tab[11] = '{4'd0,  KEY_FIPS};

        rst       = 1'b1;
        key_in    = '0;
        key_valid = 1'b0;
        rk_rd     = 1'b0;
        rk_idx    = '0;
`ifdef AES_KS_ZEROIZE_EN
        zeroize   = 1'b0;
`endif
        step();
        step();
        chk_reset_vals("reset");
        rst = 1'b0;
        step();

        // FIPS key: keys_ready exactly 10 edges after accept; read during EXPAND dropped
        key_in    = KEY_FIPS;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        chk1("accept busy", busy, 1'b1);
        chk1("accept key_ready", key_ready, 1'b0);
        chk1("accept keys_ready", keys_ready, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            if (k == 3) begin
                rk_rd     = 1'b1;
                rk_idx    = 4'd5;
                key_valid = 1'b1;
                key_in    = 128'h0;
            end
            step();
            rk_rd     = 1'b0;
            key_valid = 1'b0;
            chk1($sformatf("expand E%0d keys_ready", k), keys_ready, (k == 10));
            if (k == 3) begin
                chk1("expand read rk_vld", rk_vld, 1'b0);
                chk1("expand read busy", busy, 1'b1);
            end
        end
        chk1("ready busy", busy, 1'b0);
        chk1("ready key_ready", key_ready, 1'b1);

        // Reverse sweep on consecutive cycles, including an out-of-range index
        for (int i = 0; i < 12; i++) begin
            rk_rd  = 1'b1;
            rk_idx = tab[i].idx;
            step();
            chk1($sformatf("sweep idx%0d vld", tab[i].idx), rk_vld, 1'b1);
            chk128($sformatf("sweep idx%0d key", tab[i].idx), rk_out, tab[i].exp);
        end
        rk_rd = 1'b0;
        step();
        chk1("idle read vld", rk_vld, 1'b0);
        chk128("idle read holds", rk_out, KEY_FIPS);

        // Rekey with simultaneous read returns the old key
        key_in    = 128'h0;
        key_valid = 1'b1;
        rk_rd     = 1'b1;
        rk_idx    = 4'd0;
        step();
        key_valid = 1'b0;
        chk1("rekey read vld", rk_vld, 1'b1);
        chk128("rekey read old key", rk_out, KEY_FIPS);
        chk1("rekey keys_ready", keys_ready, 1'b0);
        rk_idx = 4'd10;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k < 10) begin
                chk1($sformatf("rekey E%0d vld", k), rk_vld, 1'b0);
                chk128($sformatf("rekey E%0d hold", k), rk_out, KEY_FIPS);
            end
            chk1($sformatf("rekey E%0d keys_ready", k), keys_ready, (k == 10));
        end
        rk_rd = 1'b0;
        read_key("zero idx10", 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        read_key("zero idx1", 4'd1, 128'h62636363626363636263636362636363);

        // Reset asserted asynchronously in expansion cycle 6
        key_in    = KEY_FIPS;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        repeat (5) step();
        chk1("pre-reset busy", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("async reset");
        step();
        rst = 1'b0;
        step();
        key_in    = KEY_C1;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        repeat (10) step();
        chk1("c1 keys_ready", keys_ready, 1'b1);
        read_key("c1 idx0", 4'd0, KEY_C1);
        read_key("c1 idx1", 4'd1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        read_key("c1 idx10", 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5);

`ifdef AES_KS_ZEROIZE_EN
        // Zeroize in READY wipes store and output register
        zeroize = 1'b1;
        rk_rd   = 1'b1;
        rk_idx  = 4'd1;
        step();
        zeroize = 1'b0;
        rk_rd   = 1'b0;
        chk_reset_vals("zeroize");
        key_in    = 128'h0;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        chk1("post-zeroize accept busy", busy, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
